// File: rtl/sfifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags, flush, and selectable FWFT or registered read.
module sfifo_prog #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned RD_MODE    = 0
) (
    input  logic                             clk,
    input  logic                             srst,
    input  logic                             flush,
    input  logic                             wren,
    input  logic [DATA_WIDTH-1:0]            wdata,
    input  logic                             rden,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic                             rvalid,
    input  logic [$clog2(DEPTH+1)-1:0]       af_thr,
    input  logic [$clog2(DEPTH+1)-1:0]       ae_thr,
    output logic [$clog2(DEPTH+1)-1:0]       count,
    output logic                             full,
    output logic                             empty,
    output logic                             almost_full,
    output logic                             almost_empty,
    output logic                             overflow,
    output logic                             underflow,
    input  logic                             err_clr
);

    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_W-1:0]     wrptr;
    logic [ADDR_W-1:0]     rdptr;
    logic                  wr_acc;
    logic                  rd_acc;

    // Acceptance is judged on pre-edge flags, so a write into a full FIFO is
    // rejected even when a read frees a slot on the same edge.
    assign wr_acc = wren && !full;
    assign rd_acc = rden && !empty;

    assign full         = (count == CNT_W'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= af_thr);
    assign almost_empty = (count <= ae_thr);

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wrptr <= '0;
            rdptr <= '0;
            count <= '0;
        end else begin
            if (wr_acc) begin
                wrptr <= (wrptr == ADDR_W'(DEPTH - 1)) ? '0 : wrptr + ADDR_W'(1);
            end
            if (rd_acc) begin
                rdptr <= (rdptr == ADDR_W'(DEPTH - 1)) ? '0 : rdptr + ADDR_W'(1);
            end
            count <= count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        end
    end

    // Storage is deliberately left unreset
    always_ff @(posedge clk) begin
        if (!srst && !flush && wr_acc) begin
            mem[wrptr] <= wdata;
        end
    end

    // Sticky error flags; a new event outranks err_clr, flush masks events
    always_ff @(posedge clk) begin
        if (srst) begin
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            overflow  <= (wren && full && !flush)  || (overflow  && !err_clr);
            underflow <= (rden && empty && !flush) || (underflow && !err_clr);
        end
    end

    generate
        if (RD_MODE == 0) begin : g_fwft
            assign rdata  = mem[rdptr];
            assign rvalid = !empty;
        end else begin : g_reg
            // One-cycle read latency; rdata holds between accepted reads
            always_ff @(posedge clk) begin
                if (srst) begin
                    rdata  <= '0;
                    rvalid <= 1'b0;
                end else if (flush) begin
                    rvalid <= 1'b0;
                end else begin
                    rvalid <= rd_acc;
                    if (rd_acc) begin
                        rdata <= mem[rdptr];
                    end
                end
            end
        end
    endgenerate

endmodule
